// File: rtl/sv_sys_pkg.sv
// Shared definitions for the system register-bus peripherals: timer register
// offsets, timer control-bit layout and the per-timer address helper.
package sv_sys_pkg;

    // Per-timer register offsets relative to the timer's base (base = 2*index).
    localparam logic [3:0] TMR_CNT     = 4'h0;
    localparam logic [3:0] TMR_CTRL    = 4'h1;
    // Bank-wide status registers.
    localparam logic [3:0] TMR_STAT    = 4'hE;
    localparam logic [3:0] TMR_STAT_RC = 4'hF;

    // Control register bit indices.
    localparam int CTRL_RUN  = 0;
    localparam int CTRL_IEN  = 1;
    localparam int CTRL_LONG = 2;
    localparam int CTRL_AUTO = 3;
    localparam int CTRL_W    = 4;

    // Control register as stored; member order matches the bit indices above.
    typedef struct packed {
        logic autorl;   // bit 3: reload on expiry
        logic long_p;   // bit 2: long prescale
        logic ien;      // bit 1: IRQ enable
        logic run;      // bit 0: timer running
    } tmr_ctrl_t;

    // Absolute register offset of a timer register.
    function automatic logic [3:0] tmr_offset(input int unsigned idx, input logic [3:0] base);
        return 4'(2 * idx) + base;
    endfunction

endpackage

// File: rtl/sv_timer_channel.sv
// One down-counting interval timer: prescaler, count, reload value and control.
// The expire pulse is combinational and lasts exactly the cycle whose edge
// moves the count off 1 (or the cycle of a zero write while running).
module sv_timer_channel
    import sv_sys_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int PRESC_SHORT = 256,
    parameter int PRESC_LONG  = 16384,
    parameter int DIV_W       = 14
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic             cnt_we_i,
    input  logic             ctrl_we_i,
    input  logic [7:0]       din_i,
    output logic [CNT_W-1:0] count_o,
    output tmr_ctrl_t        ctrl_o,
    output logic             expire_o
);

    localparam logic [DIV_W-1:0] SHORT_M1 = DIV_W'(PRESC_SHORT - 1);
    localparam logic [DIV_W-1:0] LONG_M1  = DIV_W'(PRESC_LONG - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] period_m1;
    tmr_ctrl_t        ctrl_q, ctrl_d;
    logic             expire;

    // Next-state: a count write wins over the prescaler/tick path in the same cycle.
    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        ctrl_d    = ctrl_q;
        expire    = 1'b0;
        period_m1 = ctrl_q.long_p ? LONG_M1 : SHORT_M1;

        if (ctrl_we_i) begin
            ctrl_d = tmr_ctrl_t'(din_i[CTRL_W-1:0]);
        end

        if (cnt_we_i) begin
            count_d  = din_i[CNT_W-1:0];
            reload_d = din_i[CNT_W-1:0];
            presc_d  = period_m1;
            // Legacy behaviour: writing zero to a running timer reports an expiry.
            expire   = ctrl_q.run && (din_i[CNT_W-1:0] == '0);
        end else if (ctrl_q.run && ce_i) begin
            if (presc_q != '0) begin
                presc_d = presc_q - DIV_W'(1);
            end else begin
                // Prescale change is picked up here, at the reload.
                presc_d = period_m1;
                if (count_q == CNT_W'(1)) begin
                    expire  = 1'b1;
                    count_d = ctrl_q.autorl ? reload_q : '0;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            ctrl_q   <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign count_o  = count_q;
    assign ctrl_o   = ctrl_q;
    assign expire_o = expire;

endmodule

// File: rtl/sv_timer_bank.sv
// Bank of NUM_TIMERS interval timers on the system register bus. Owns the
// address decode, the shared sticky status register, the registered read
// port and the registered IRQ output.
module sv_timer_bank
    import sv_sys_pkg::*;
#(
    parameter int NUM_TIMERS  = 2,
    parameter int CNT_W       = 8,
    parameter int PRESC_SHORT = 256,
    parameter int PRESC_LONG  = 16384,
    parameter int DIV_W       = 14
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cpu_ce,
    input  logic       cs,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    logic [CNT_W-1:0]      count [NUM_TIMERS];
    tmr_ctrl_t             ctrl  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] expire;
    logic [NUM_TIMERS-1:0] ien;
    logic [NUM_TIMERS-1:0] status_q, status_d, clr;
    logic [7:0]            rdata, dout_q, dout_d;
    logic                  irq_q, irq_d;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tmr
        sv_timer_channel #(
            .CNT_W      (CNT_W),
            .PRESC_SHORT(PRESC_SHORT),
            .PRESC_LONG (PRESC_LONG),
            .DIV_W      (DIV_W)
        ) u_chan (
            .clk_i    (clk_sys),
            .rst_ni   (reset_n),
            .ce_i     (cpu_ce),
            .cnt_we_i (cs && we && (addr == tmr_offset(g, TMR_CNT))),
            .ctrl_we_i(cs && we && (addr == tmr_offset(g, TMR_CTRL))),
            .din_i    (din),
            .count_o  (count[g]),
            .ctrl_o   (ctrl[g]),
            .expire_o (expire[g])
        );
        assign ien[g] = ctrl[g].ien;
    end

    // Read mux; unmapped offsets and unused upper bits read as zero.
    always_comb begin
        rdata = 8'h00;
        if (addr == TMR_STAT || addr == TMR_STAT_RC) begin
            rdata = 8'(status_q);
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (addr == tmr_offset(i, TMR_CNT))  rdata = 8'(count[i]);
                if (addr == tmr_offset(i, TMR_CTRL)) rdata = 8'(ctrl[i]);
            end
        end
    end

    // Status update: a new expiry always survives a same-cycle clear.
    always_comb begin
        clr = '0;
        if (cs && we && addr == TMR_STAT)     clr = din[NUM_TIMERS-1:0];
        if (cs && !we && addr == TMR_STAT_RC) clr = '1;
        status_d = (status_q & ~clr) | expire;
        irq_d    = |(status_q & ien);
        dout_d   = (cs && !we) ? rdata : dout_q;
    end

    // Status, read data and IRQ registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= '0;
            dout_q   <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            dout_q   <= dout_d;
            irq_q    <= irq_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_sv_timer_bank.sv
// Bench for sv_timer_bank (3 timers): directed scenarios with literal
// expectations plus randomized bus traffic, all compared cycle by cycle
// against a behavioural model of the register-level behaviour.
module tb_sv_timer_bank;

    localparam int NT = 3;
    localparam int PS = 256;
    localparam int PL = 16384;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       cpu_ce, cs, we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    sv_timer_bank #(
        .NUM_TIMERS (NT),
        .CNT_W      (8),
        .PRESC_SHORT(PS),
        .PRESC_LONG (PL),
        .DIV_W      (14)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .cpu_ce (cpu_ce),
        .cs     (cs),
        .we     (we),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .irq    (irq)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [NT];
    int m_rel [NT];
    int m_presc [NT];
    int m_ctrl [NT];
    int m_stat, m_dout, m_irq;

    task automatic m_reset();
        for (int i = 0; i < NT; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_presc[i] = 0; m_ctrl[i] = 0;
        end
        m_stat = 0; m_dout = 0; m_irq = 0;
    endtask

    function automatic int m_read(input int a);
        if (a == 14 || a == 15) return m_stat;
        if ((a >> 1) < NT) return (a & 1) ? m_ctrl[a >> 1] : m_cnt[a >> 1];
        return 0;
    endfunction

    // One clock edge of the register-level rules, using pre-edge state.
    task automatic m_step();
        int n_cnt [NT];
        int n_rel [NT];
        int n_presc [NT];
        int n_ctrl [NT];
        int set, clr, ien, a, d, period;
        bit run;
        set = 0; clr = 0; ien = 0;
        a = int'(addr);
        d = int'(din);
        for (int i = 0; i < NT; i++) if (m_ctrl[i] & 2) ien |= (1 << i);
        if (cs && !we) m_dout = m_read(a);
        for (int i = 0; i < NT; i++) begin
            n_cnt[i] = m_cnt[i]; n_rel[i] = m_rel[i];
            n_presc[i] = m_presc[i]; n_ctrl[i] = m_ctrl[i];
            run    = (m_ctrl[i] & 1) != 0;
            period = (m_ctrl[i] & 4) ? PL : PS;
            if (cs && we && a == 2 * i) begin
                n_cnt[i] = d; n_rel[i] = d; n_presc[i] = period - 1;
                if (run && d == 0) set |= (1 << i);
            end else if (run && cpu_ce) begin
                if (m_presc[i] > 0) begin
                    n_presc[i] = m_presc[i] - 1;
                end else begin
                    n_presc[i] = period - 1;
                    if (m_cnt[i] == 1) begin
                        set |= (1 << i);
                        n_cnt[i] = (m_ctrl[i] & 8) ? m_rel[i] : 0;
                    end else if (m_cnt[i] > 1) begin
                        n_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
            if (cs && we && a == 2 * i + 1) n_ctrl[i] = d & 15;
        end
        if (cs && we && a == 14)  clr = d & ((1 << NT) - 1);
        if (cs && !we && a == 15) clr = (1 << NT) - 1;
        m_irq  = ((m_stat & ien) != 0) ? 1 : 0;
        m_stat = (m_stat & ~clr) | set;
        for (int i = 0; i < NT; i++) begin
            m_cnt[i] = n_cnt[i]; m_rel[i] = n_rel[i];
            m_presc[i] = n_presc[i]; m_ctrl[i] = n_ctrl[i];
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison of the outputs against the model.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (cmp_en) begin
                check("dout", dout, m_dout);
                check("irq", irq, m_irq);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk_sys);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk_sys);
        cs = 1'b0;
        v = dout;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, dout=0x%0h irq=%0b", dout, irq);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        int r;
        reset_n = 1'b0;
        cpu_ce = 1'b0; cs = 1'b0; we = 1'b0; addr = 4'h0; din = 8'h00;
        cyc(3);
        check("rst_dout", dout, 0);
        check("rst_irq", irq, 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        cyc(1);

        // Short prescale one-shot: 3 counts x 256 ticks.
        wr(4'h0, 8'd3);
        wr(4'h1, 8'h03);
        cpu_ce = 1'b1;
        cyc(767);
        rd(4'hE, v); check("t1_before_expiry", v, 8'h00);
        rd(4'hE, v); check("t1_status", v, 8'h01);
        check("t1_irq", irq, 1);
        rd(4'hF, v); check("t1_read_clear", v, 8'h01);
        cyc(1);      check("t1_irq_cleared", irq, 0);
        rd(4'hE, v); check("t1_status_cleared", v, 8'h00);
        rd(4'h0, v); check("t1_count_zero", v, 8'h00);

        // Long prescale auto-reload on T1: first expiry after 2 x 16384 ticks.
        cpu_ce = 1'b0;
        wr(4'h3, 8'h0E);
        wr(4'h2, 8'd2);
        wr(4'h3, 8'h0F);
        cpu_ce = 1'b1;
        cyc(32767);
        rd(4'hE, v); check("t2_before_expiry", v, 8'h00);
        rd(4'hE, v); check("t2_status", v, 8'h02);
        rd(4'h2, v); check("t2_reloaded", v, 8'h02);
        rd(4'h3, v); check("t2_ctrl_read", v, 8'h0F);
        wr(4'hE, 8'h02);
        wr(4'h3, 8'h00);

        // One-shot expires once; then legacy zero write.
        wr(4'h0, 8'd1);
        cyc(300);
        rd(4'hF, v); check("t3_first_expiry", v, 8'h01);
        cyc(600);
        rd(4'hE, v); check("t3_no_second", v, 8'h00);
        rd(4'h0, v); check("t3_count_stays0", v, 8'h00);
        wr(4'h0, 8'd0);
        rd(4'hE, v); check("t3_zero_write", v, 8'h01);
        wr(4'hE, 8'h01);

        // Expiry beats W1C in the same cycle; count write beats tick.
        wr(4'h0, 8'd1);
        cyc(255);
        wr(4'hE, 8'h01);
        rd(4'hE, v); check("t4_expiry_beats_w1c", v, 8'h01);
        wr(4'hE, 8'h01);
        wr(4'h0, 8'd2);
        cyc(255);
        wr(4'h0, 8'h40);
        rd(4'h0, v); check("t4_write_beats_tick", v, 8'h40);
        wr(4'h1, 8'h00);

        // Masking: T0 and T2 expire, only T2 enabled.
        cpu_ce = 1'b0;
        wr(4'hE, 8'h07);
        wr(4'h0, 8'd1);
        wr(4'h4, 8'd1);
        wr(4'h1, 8'h01);
        wr(4'h5, 8'h03);
        cpu_ce = 1'b1;
        cyc(260);
        rd(4'hE, v); check("t5_status", v, 8'h05);
        check("t5_irq", irq, 1);
        wr(4'hE, 8'h04);
        cyc(1);      check("t5_irq_masked", irq, 0);
        rd(4'hE, v); check("t5_status_left", v, 8'h01);
        wr(4'hE, 8'h01);
        wr(4'h1, 8'h00);

        // Asynchronous reset mid-count with status and irq set.
        wr(4'h4, 8'd0);
        cyc(1);      check("t6_irq_before", irq, 1);
        wr(4'h0, 8'd5);
        wr(4'h1, 8'h01);
        rd(4'hE, v); check("t6_status_before", v, 8'h04);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("t6_irq_in_reset", irq, 0);
        check("t6_dout_in_reset", dout, 0);
        @(negedge clk_sys);
        cyc(2);
        reset_n = 1'b1;
        cyc(1000);
        check("t6_irq_after", irq, 0);
        rd(4'hE, v); check("t6_status_after", v, 8'h00);
        rd(4'h0, v); check("t6_count0_after", v, 8'h00);
        rd(4'h1, v); check("t6_ctrl0_after", v, 8'h00);

        // Randomized traffic; the compare process checks every cycle.
        for (int k = 0; k < 20000; k++) begin
            cpu_ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 99);
                if (r < 5) begin
                    cs = 1'b1; we = 1'b1;
                    addr = 4'(2 * $urandom_range(0, NT - 1));
                    din  = 8'($urandom_range(0, 3));
                end else if (r < 30) begin
                    cs = 1'b1; we = 1'b1;
                    addr = 4'(2 * $urandom_range(0, NT - 1) + 1);
                    din  = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) != 0) din[0] = 1'b1;
                    if ($urandom_range(0, 3) != 0) din[2] = 1'b0;
                end else if (r < 85) begin
                    cs = 1'b1; we = 1'b0;
                    addr = 4'($urandom_range(0, 15));
                end else begin
                    cs = 1'b1; we = 1'b1;
                    addr = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
                    din  = 8'($urandom_range(0, 255));
                end
                @(negedge clk_sys);
                cs = 1'b0; we = 1'b0;
            end else begin
                @(negedge clk_sys);
            end
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
